core_out_uart: RTL

Output-side peripheral for the 16-bit core: it consumes the core's `out_en`/`out_dat` write strobe, buffers the words in a FIFO and serialises them onto a UART TX line. It sits beside `imem`/`dmem` at the top level and is the sink end of the core's output port. A drain indicator lets the top level or bench tell when every word the core emitted before `is_halt` has left the wire.

---
 rtl/core_io_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/core_out_uart.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_io_pkg.sv
// rtl/core_io_pkg.sv - shared types and constants for the core output UART
package core_io_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic STOP_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Even parity: the bit that makes the total number of ones even
    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO still accepts a word when the head leaves on the same edge
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/core_out_uart.sv
// rtl/core_out_uart.sv - core output FIFO and UART serialiser; CORE_OUT_UART_PARITY_EN adds even parity
module core_out_uart
    import core_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              out_en,
    input  logic [WORD_W-1:0] out_dat,
    input  logic              is_halt,
    output logic              tx,
    output logic              full,
    output logic [7:0]        ovf_cnt,
    output logic              done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic              r_hi;
    logic [WORD_W-1:0] r_word;
    logic              r_tx;
    logic [7:0]        r_ovf_cnt;

    uart_state_t       w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic              w_hi_nxt;
    logic [WORD_W-1:0] w_word_nxt;
    logic              w_pop;
    logic              w_tx_nxt;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic              w_baud_done;
    logic              w_drop;

    logic [WORD_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (out_en),
        .i_wdata (out_dat),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_drop      = out_en && w_fifo_full && !w_pop;

    // State register plus the datapath registers that move with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_hi      <= 1'b0;
            r_word    <= '0;
            r_tx      <= STOP_BIT;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_hi      <= w_hi_nxt;
            r_word    <= w_word_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Next-state logic: bit timing, byte sequencing and FIFO pops
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + BAUD_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_hi_nxt    = r_hi;
        w_word_nxt  = r_word;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_word_nxt  = w_fifo_rdata;
                    w_hi_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef CORE_OUT_UART_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef CORE_OUT_UART_PARITY_EN
            PARITY: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!r_hi) begin
                        w_hi_nxt    = 1'b1;
                        w_state_nxt = START;
                    end else if (!w_fifo_empty) begin
                        // Next word starts straight after this stop bit
                        w_pop       = 1'b1;
                        w_word_nxt  = w_fifo_rdata;
                        w_hi_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, taken from the next state so tx is a flop
    always_comb begin
        w_tx_nxt   = STOP_BIT;
        w_byte_nxt = w_hi_nxt ? w_word_nxt[WORD_W-1:BYTE_W] : w_word_nxt[BYTE_W-1:0];
        case (w_state_nxt)
            START:   w_tx_nxt = START_BIT;
            DATA:    w_tx_nxt = w_byte_nxt[w_bit_nxt];
`ifdef CORE_OUT_UART_PARITY_EN
            PARITY:  w_tx_nxt = even_parity(w_byte_nxt);
`endif
            default: w_tx_nxt = STOP_BIT;
        endcase
    end

    // Dropped-word counter, saturating, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign tx      = r_tx;
    assign ovf_cnt = r_ovf_cnt;
    assign full    = (w_fifo_count == CNT_W'(FIFO_DEPTH));
    assign done    = is_halt && w_fifo_empty && (r_state == IDLE);

endmodule
